// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    // Timer must hold the largest terminal value (parameter - 1); never narrower than 1 bit.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL locked flag into the refclk domain.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock stability and releases the downstream system reset;
// retries failed lock attempts and parks in a sticky fault once the retry budget is spent.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             clear_fault,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RETRY_W = count_width(MAX_RETRIES);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    sup_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retries;
    logic [CNT_W-1:0]   loss_cnt;
    logic               locked_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (locked),
        .q      (locked_s)
    );

    // Every transition below also clears the timer; timed states leave before it can wrap.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= PLL_RESET;
            timer    <= '0;
            retries  <= '0;
            loss_cnt <= '0;
        end else begin
            timer <= timer + 1'b1;
            case (state)
                PLL_RESET: begin
                    if (timer == RST_LAST) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer <= '0;
                        if (retries == RETRY_MAX) begin
                            state <= FAULT;
                        end else begin
                            retries <= retries + 1'b1;
                            state   <= PLL_RESET;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state   <= RUN;
                        timer   <= '0;
                        retries <= '0;
                    end
                end
                RUN: begin
                    timer <= timer;
                    if (!locked_s) begin
                        state    <= PLL_RESET;
                        timer    <= '0;
                        loss_cnt <= sat_inc(loss_cnt);
                    end
                end
                FAULT: begin
                    timer <= timer;
                    if (clear_fault) begin
                        state   <= PLL_RESET;
                        timer   <= '0;
                        retries <= '0;
                    end
                end
                default: begin
                    state <= PLL_RESET;
                    timer <= '0;
                end
            endcase
        end
    end

    // Moore decode straight off the state register.
    assign pll_rst       = (state == PLL_RESET);
    assign sys_rst       = (state != RUN);
    assign ready         = (state == RUN);
    assign fault         = (state == FAULT);
    assign lock_loss_cnt = loss_cnt;

endmodule
